// File: rtl/sap_pkg.sv
// Shared definitions for the parametrised SAP core.
// Opcodes, FSM states, bus sources and the control word.
package sap_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        ST_T1   = 3'd0,
        ST_T2   = 3'd1,
        ST_T3   = 3'd2,
        ST_T4   = 3'd3,
        ST_T5   = 3'd4,
        ST_HALT = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        BUS_NONE = 3'd0,
        BUS_PC   = 3'd1,
        BUS_OPND = 3'd2,
        BUS_RAM  = 3'd3,
        BUS_A    = 3'd4,
        BUS_ALU  = 3'd5
    } bus_sel_e;

    typedef struct packed {
        logic     pc_incr;
        logic     pc_load;
        logic     mar_load;
        logic     ram_read;
        logic     ram_write;
        logic     ir_load;
        logic     a_load;
        logic     b_load;
        logic     alu_sub;
        logic     flags_load;
        logic     out_load;
        bus_sel_e bus_sel;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/sap_controller_fsm.sv
// Variable-length T-state sequencer for the SAP core.
// In: opcode, flags, freeze, reset. Out: control word, state.
import sap_pkg::*;

module sap_controller_fsm (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_freeze,
    input  logic [3:0] i_opcode,
    input  logic       i_carry,
    input  logic       i_zero,
    output ctrl_t      o_ctrl,
    output state_e     o_state
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl;

    always_comb begin
        state_d = state_q;
        ctrl    = CTRL_IDLE;
        unique case (state_q)
            ST_T1: begin
                ctrl.mar_load = 1'b1;
                ctrl.bus_sel  = BUS_PC;
                state_d       = ST_T2;
            end
            ST_T2: begin
                ctrl.ir_load  = 1'b1;
                ctrl.ram_read = 1'b1;
                ctrl.bus_sel  = BUS_RAM;
                ctrl.pc_incr  = 1'b1;
                state_d       = ST_T3;
            end
            ST_T3: begin
                state_d = ST_T1;
                case (i_opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ctrl.mar_load = 1'b1;
                        ctrl.bus_sel  = BUS_OPND;
                        state_d       = ST_T4;
                    end
                    OP_LDI: begin
                        ctrl.a_load  = 1'b1;
                        ctrl.bus_sel = BUS_OPND;
                    end
                    OP_JMP: begin
                        ctrl.pc_load = 1'b1;
                        ctrl.bus_sel = BUS_OPND;
                    end
                    OP_JC: begin
                        ctrl.pc_load = i_carry;
                        ctrl.bus_sel = BUS_OPND;
                    end
                    OP_JZ: begin
                        ctrl.pc_load = i_zero;
                        ctrl.bus_sel = BUS_OPND;
                    end
                    OP_OUT: begin
                        ctrl.out_load = 1'b1;
                        ctrl.bus_sel  = BUS_A;
                    end
                    OP_HLT: state_d = ST_HALT;
                    default: ;
                endcase
            end
            ST_T4: begin
                state_d = ST_T1;
                case (i_opcode)
                    OP_LDA: begin
                        ctrl.a_load   = 1'b1;
                        ctrl.ram_read = 1'b1;
                        ctrl.bus_sel  = BUS_RAM;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl.b_load   = 1'b1;
                        ctrl.ram_read = 1'b1;
                        ctrl.bus_sel  = BUS_RAM;
                        state_d       = ST_T5;
                    end
                    OP_STA: begin
                        ctrl.ram_write = 1'b1;
                        ctrl.bus_sel   = BUS_A;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                ctrl.a_load     = 1'b1;
                ctrl.flags_load = 1'b1;
                ctrl.alu_sub    = (i_opcode == OP_SUB);
                ctrl.bus_sel    = BUS_ALU;
                state_d         = ST_T1;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_T1;
        endcase
        // Freeze and reset both suppress every side effect;
        // reset additionally drops a partly executed instruction.
        if (i_freeze) begin
            ctrl    = CTRL_IDLE;
            state_d = state_q;
        end
        if (i_reset) begin
            ctrl    = CTRL_IDLE;
            state_d = ST_T1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) state_q <= ST_T1;
        else         state_q <= state_d;
    end

    assign o_ctrl  = ctrl;
    assign o_state = state_q;

endmodule

// File: rtl/sap_core_param.sv
// Parametrised SAP accumulator CPU: datapath, bus mux and RAM.
// Ports: clk/reset, programming port, display, status flags, PC.
import sap_pkg::*;

module sap_core_param #(
    parameter int ADDR_WIDTH = 4,
    localparam int DATA_WIDTH = 4 + ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_program_mode,
    input  logic                  i_program_write,
    input  logic [ADDR_WIDTH-1:0] i_program_address,
    input  logic [DATA_WIDTH-1:0] i_program_data,
    output logic [DATA_WIDTH-1:0] o_display,
    output logic                  o_display_valid,
    output logic                  o_halted,
    output logic                  o_carry,
    output logic                  o_zero,
    output logic [ADDR_WIDTH-1:0] o_pc
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] ram_q [DEPTH];

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] mar_q, mar_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  carry_q, carry_d;
    logic                  zero_q, zero_d;
    logic                  valid_q, valid_d;

    ctrl_t  ctrl;
    state_e state;

    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [DATA_WIDTH-1:0] opnd;
    logic [DATA_WIDTH:0]   alu;
    logic [DATA_WIDTH-1:0] bus;

    sap_controller_fsm u_fsm (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_freeze (i_program_mode),
        .i_opcode (ir_q[DATA_WIDTH-1 -: 4]),
        .i_carry  (carry_q),
        .i_zero   (zero_q),
        .o_ctrl   (ctrl),
        .o_state  (state)
    );

    assign ram_rdata = ctrl.ram_read ? ram_q[mar_q] : '0;
    assign opnd      = {4'b0, ir_q[ADDR_WIDTH-1:0]};

    // Subtract as A + ~B + 1 so the carry-out means "no borrow".
    always_comb begin
        if (ctrl.alu_sub)
            alu = {1'b0, a_q} + {1'b0, ~b_q} + 1'b1;
        else
            alu = {1'b0, a_q} + {1'b0, b_q};
    end

    always_comb begin
        bus = '0;
        unique case (ctrl.bus_sel)
            BUS_PC:   bus = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, pc_q};
            BUS_OPND: bus = opnd;
            BUS_RAM:  bus = ram_rdata;
            BUS_A:    bus = a_q;
            BUS_ALU:  bus = alu[DATA_WIDTH-1:0];
            default:  bus = '0;
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        mar_d   = mar_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        valid_d = ctrl.out_load;
        if (ctrl.pc_load)
            pc_d = bus[ADDR_WIDTH-1:0];
        else if (ctrl.pc_incr)
            pc_d = pc_q + 1'b1;
        if (ctrl.mar_load) mar_d = bus[ADDR_WIDTH-1:0];
        if (ctrl.ir_load)  ir_d  = bus;
        if (ctrl.a_load)   a_d   = bus;
        if (ctrl.b_load)   b_d   = bus;
        if (ctrl.out_load) out_d = bus;
        if (ctrl.flags_load) begin
            carry_d = alu[DATA_WIDTH];
            zero_d  = (alu[DATA_WIDTH-1:0] == '0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pc_q    <= '0;
            mar_q   <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            mar_q   <= mar_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            valid_q <= valid_d;
        end
    end

    // RAM survives reset; the programming port works even in reset/HALT.
    always_ff @(posedge i_clk) begin
        if (i_program_mode && i_program_write)
            ram_q[i_program_address] <= i_program_data;
        else if (ctrl.ram_write)
            ram_q[mar_q] <= bus;
    end

    assign o_display       = out_q;
    assign o_display_valid = valid_q;
    assign o_halted        = (state == ST_HALT);
    assign o_carry         = carry_q;
    assign o_zero          = zero_q;
    assign o_pc            = pc_q;

endmodule

// File: tb/tb_sap_core_param.sv
// Directed self-checking bench for sap_core_param (ADDR_WIDTH=4).
// Linear program/run/check steps with immediate assertions.
import sap_pkg::*;

module tb_sap_core_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pmode = 1'b1;
    logic       pwrite = 1'b0;
    logic [3:0] paddr = '0;
    logic [7:0] pdata = '0;
    logic [7:0] display;
    logic       valid;
    logic       halted;
    logic       carry;
    logic       zero;
    logic [3:0] pc;

    int n_assert = 0;
    int n_fail   = 0;
    int pulses;
    logic [7:0] last_disp;
    logic ok;

    sap_core_param #(.ADDR_WIDTH(4)) dut (
        .i_clk             (clk),
        .i_reset           (reset),
        .i_program_mode    (pmode),
        .i_program_write   (pwrite),
        .i_program_address (paddr),
        .i_program_data    (pdata),
        .o_display         (display),
        .o_display_valid   (valid),
        .o_halted          (halted),
        .o_carry           (carry),
        .o_zero            (zero),
        .o_pc              (pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic prog(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        pmode  = 1'b1;
        pwrite = 1'b1;
        paddr  = a;
        pdata  = d;
        @(negedge clk);
        pwrite = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        pmode = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_halt(input int max);
        pulses = 0;
        for (int i = 0; i < max && !halted; i++) begin
            @(negedge clk);
            if (valid) begin
                pulses++;
                last_disp = display;
            end
        end
        chk("halt_timeout", 32'(halted), 32'd1);
    endtask

    task automatic wait_valid(input int max);
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk);
            if (valid) ok = 1'b1;
        end
    endtask

    initial begin
        // 1: LDA 9, ADD A, OUT, HLT -> 0x0A + 0x14 = 0x1E
        prog(4'h0, 8'h19);
        prog(4'h1, 8'h2A);
        prog(4'h2, 8'hE0);
        prog(4'h3, 8'hF0);
        prog(4'h9, 8'h0A);
        prog(4'hA, 8'h14);
        do_reset();
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_disp", 32'(display), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_halt", 32'(halted), 32'h0);
        chk("rst_flags", {30'b0, carry, zero}, 32'h0);
        pulses = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (valid) begin
                pulses++;
                last_disp = display;
            end
            if (c == 14) chk("t1_halt14", 32'(halted), 32'h0);
            if (c == 15) chk("t1_halt15", 32'(halted), 32'h1);
        end
        chk("t1_halt_held", 32'(halted), 32'h1);
        chk("t1_pulses", 32'(pulses), 32'd1);
        chk("t1_disp", 32'(last_disp), 32'h1E);

        // 2: LDI F, ADD E(0xF1) -> 0 c=1 z=1; JZ 8 taken
        prog(4'h0, 8'h5F);
        prog(4'h1, 8'h2E);
        prog(4'h2, 8'h88);
        prog(4'hE, 8'hF1);
        prog(4'h8, 8'hE0);
        prog(4'h9, 8'hF0);
        do_reset();
        chk("t2_unhalt", 32'(halted), 32'h0);
        step(8);
        chk("t2_carry", 32'(carry), 32'h1);
        chk("t2_zero", 32'(zero), 32'h1);
        step(3);
        chk("t2_jz_pc", 32'(pc), 32'h8);
        run_halt(40);
        chk("t2_pulses", 32'(pulses), 32'd1);
        chk("t2_disp", 32'(last_disp), 32'h00);

        // 3: LDI 3, SUB E(0x05) -> FE c=0 z=0; JC C not taken
        prog(4'h0, 8'h53);
        prog(4'h1, 8'h3E);
        prog(4'h2, 8'h7C);
        prog(4'h3, 8'hE0);
        prog(4'h4, 8'hF0);
        prog(4'hE, 8'h05);
        prog(4'hC, 8'hF0);
        do_reset();
        step(8);
        chk("t3_carry", 32'(carry), 32'h0);
        chk("t3_zero", 32'(zero), 32'h0);
        step(3);
        chk("t3_jc_pc", 32'(pc), 32'h3);
        run_halt(40);
        chk("t3_pulses", 32'(pulses), 32'd1);
        chk("t3_disp", 32'(last_disp), 32'hFE);
        chk("t3_pc_end", 32'(pc), 32'h5);

        // 4: counter loop in RAM[F], step RAM[E]=1
        prog(4'h0, 8'h1F);
        prog(4'h1, 8'h2E);
        prog(4'h2, 8'h4F);
        prog(4'h3, 8'hE0);
        prog(4'h4, 8'h60);
        prog(4'hE, 8'h01);
        prog(4'hF, 8'h00);
        do_reset();
        for (int k = 1; k <= 256; k++) begin
            wait_valid(40);
            chk("t4_timeout", 32'(ok), 32'h1);
            chk("t4_disp", 32'(display), 32'(k % 256));
            if (k <= 3 || k == 256)
                chk("t4_ram", 32'(dut.ram_q[15]), 32'(k % 256));
            if (k == 255) chk("t4_c255", 32'(carry), 32'h0);
            if (k == 256) begin
                chk("t4_c256", 32'(carry), 32'h1);
                chk("t4_z256", 32'(zero), 32'h1);
            end
        end

        // 5: reset lands on T4 of STA D; RAM[D] must survive
        prog(4'h0, 8'h57);
        prog(4'h1, 8'h4D);
        prog(4'h2, 8'hF0);
        prog(4'hD, 8'h33);
        do_reset();
        step(6);
        chk("t5_in_t4", 32'(dut.u_fsm.state_q), 32'(ST_T4));
        chk("t5_a_pre", 32'(dut.a_q), 32'h07);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("t5_ram", 32'(dut.ram_q[13]), 32'h33);
        chk("t5_state", 32'(dut.u_fsm.state_q), 32'(ST_T1));
        chk("t5_pc", 32'(pc), 32'h0);
        chk("t5_regs", {dut.a_q, dut.b_q, dut.ir_q, 4'h0, dut.mar_q},
            32'h0);
        chk("t5_out", 32'(display), 32'h0);
        chk("t5_flags", {30'b0, carry, zero}, 32'h0);

        // 6: freeze in ADD T4, patch RAM[5], resume
        prog(4'h0, 8'h53);
        prog(4'h1, 8'h25);
        prog(4'h2, 8'hE0);
        prog(4'h3, 8'hF0);
        prog(4'h5, 8'h04);
        prog(4'h6, 8'h11);
        do_reset();
        step(6);
        chk("t6_in_t4", 32'(dut.u_fsm.state_q), 32'(ST_T4));
        pmode  = 1'b1;
        pwrite = 1'b1;
        paddr  = 4'h5;
        pdata  = 8'h77;
        step(1);
        pwrite = 1'b0;
        paddr  = 4'h6;
        pdata  = 8'h99;
        step(3);
        chk("t6_state", 32'(dut.u_fsm.state_q), 32'(ST_T4));
        chk("t6_pc", 32'(pc), 32'h2);
        chk("t6_a", 32'(dut.a_q), 32'h03);
        chk("t6_ram5", 32'(dut.ram_q[5]), 32'h77);
        chk("t6_ram6", 32'(dut.ram_q[6]), 32'h11);
        pmode = 1'b0;
        run_halt(40);
        chk("t6_pulses", 32'(pulses), 32'd1);
        chk("t6_disp", 32'(last_disp), 32'h7A);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
